// File: rtl/io_pad_bank_seq_if.sv
// io_pad_bank_seq_if: core/pad/supply signals of one IO pad bank.
// Optional lpbk signal when IO_PAD_BANK_LOOPBACK_EN is defined.
interface io_pad_bank_seq_if #(
  parameter int CHANNELS = 8
);
  logic                pwr_good;
  logic [CHANNELS-1:0] core_oe;
  logic [CHANNELS-1:0] core_out;
  logic [CHANNELS-1:0] pad_in;
  logic [CHANNELS-1:0] pad_oe;
  logic [CHANNELS-1:0] pad_out;
  logic [CHANNELS-1:0] core_in;
  logic                ready;
  logic [1:0]          state;
`ifdef IO_PAD_BANK_LOOPBACK_EN
  logic                lpbk;

  modport master (
    output pwr_good, core_oe, core_out,
    output pad_in, lpbk,
    input  pad_oe, pad_out, core_in,
    input  ready, state
  );

  modport slave (
    input  pwr_good, core_oe, core_out,
    input  pad_in, lpbk,
    output pad_oe, pad_out, core_in,
    output ready, state
  );
`else
  modport master (
    output pwr_good, core_oe, core_out,
    output pad_in,
    input  pad_oe, pad_out, core_in,
    input  ready, state
  );

  modport slave (
    input  pwr_good, core_oe, core_out,
    input  pad_in,
    output pad_oe, pad_out, core_in,
    output ready, state
  );
`endif
endinterface

// File: rtl/io_pad_bank_seq.sv
// io_pad_bank_seq: staggered pad output-enable ramp plus input filter.
// Macro IO_PAD_BANK_LOOPBACK_EN adds lpbk self-test loopback.
module io_pad_bank_seq #(
  parameter int CHANNELS    = 8,
  parameter int GROUP       = 2,
  parameter int STEP_CYCLES = 16,
  parameter int FILT_CYCLES = 3
) (
  input logic ck,
  input logic nrst,
  io_pad_bank_seq_if.slave bus
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RAMP  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int CW = $clog2(STEP_CYCLES);
  localparam int FW = $clog2(FILT_CYCLES + 1);

  localparam logic [CHANNELS-1:0] ALL = '1;
  localparam logic [CHANNELS-1:0] GMASK =
    ALL >> (CHANNELS - GROUP);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);
  localparam logic [FW-1:0] FLAST = FW'(FILT_CYCLES - 1);

  logic                pg_q1;
  logic                pg_s;
  state_t              st;
  logic [CHANNELS-1:0] mask;
  logic [CW-1:0]       cnt;
  logic                rdy;
  logic [CHANNELS-1:0] oe_q;
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] in_q1;
  logic [CHANNELS-1:0] in_s;
  logic [CHANNELS-1:0] ci_q;
  logic [FW-1:0]       fcnt [CHANNELS];
  logic                lb;
  logic [CHANNELS-1:0] src;

`ifdef IO_PAD_BANK_LOOPBACK_EN
  assign lb = bus.lpbk;
`else
  assign lb = 1'b0;
`endif

  assign src = lb ? out_q : bus.pad_in;

  // Two-flop synchroniser for the asynchronous supply-good
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      pg_q1 <= 1'b0;
      pg_s  <= 1'b0;
    end else begin
      pg_q1 <= bus.pwr_good;
      pg_s  <= pg_q1;
    end
  end

  // Ramp sequencer; supply loss always wins over a ramp step
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      st   <= OFF;
      mask <= '0;
      cnt  <= '0;
      rdy  <= 1'b0;
    end else begin
      unique case (st)
        OFF: begin
          mask <= '0;
          cnt  <= '0;
          if (pg_s) st <= RAMP;
        end
        RAMP: begin
          if (!pg_s) begin
            st   <= DRAIN;
            mask <= '0;
            cnt  <= '0;
          end else if (mask == ALL) begin
            st  <= ON;
            cnt <= '0;
            rdy <= 1'b1;
          end else if (cnt == LAST) begin
            mask <= (mask << GROUP) | GMASK;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          if (!pg_s) begin
            st   <= DRAIN;
            mask <= '0;
            cnt  <= '0;
            rdy  <= 1'b0;
          end
        end
        DRAIN: begin
          if (cnt == LAST) begin
            st  <= OFF;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          st   <= OFF;
          mask <= '0;
          cnt  <= '0;
          rdy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered pad drive; loopback forces the drivers off
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      oe_q  <= '0;
      out_q <= '0;
    end else begin
      oe_q  <= bus.core_oe & mask & {CHANNELS{~lb}};
      out_q <= bus.core_out;
    end
  end

  // Two-flop synchroniser for every pad input
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      in_q1 <= '0;
      in_s  <= '0;
    end else begin
      in_q1 <= src;
      in_s  <= in_q1;
    end
  end

  // Per-channel filter: accept after FILT_CYCLES differing samples
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      ci_q <= '0;
      for (int i = 0; i < CHANNELS; i++)
        fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_s[i] != ci_q[i]) begin
          if (fcnt[i] == FLAST) begin
            ci_q[i] <= in_s[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign bus.pad_oe  = oe_q;
  assign bus.pad_out = out_q;
  assign bus.core_in = ci_q;
  assign bus.ready   = rdy;
  assign bus.state   = st;

endmodule
